sticker_scan_ctrl: RTL and testbench



---
 rtl/cube_pkg.sv | 49 ++++
 rtl/color_settle.sv | 68 ++++++
 rtl/sticker_scan_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_sticker_scan_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cube_pkg.sv
// cube_pkg: shared definitions for the cube scanner.
// Holds the color code width, the face color codes, the error codes reported on
// err_code, the scan controller state encoding and a helper that maps a center
// index (0..5 = U,L,F,R,B,D) to its fixed color.
package cube_pkg;

  localparam int CUBE_COLOR_W = 3;

  typedef enum logic [2:0] {
    COL_W = 3'd0,
    COL_O = 3'd1,
    COL_G = 3'd2,
    COL_R = 3'd3,
    COL_B = 3'd4,
    COL_Y = 3'd5
  } color_e;

  // Largest legal color code; anything above it is a sensor fault.
  localparam logic [2:0] COLOR_MAX = 3'd5;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_COLOR   = 2'd2
  } err_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_WAIT_MOVE = 3'd2,
    S_SETTLE    = 3'd3,
    S_STORE     = 3'd4,
    S_DONE      = 3'd5,
    S_ERROR     = 3'd6
  } scan_state_e;

  function automatic color_e center_color(input int unsigned face);
    case (face)
      32'd0:   center_color = COL_W;
      32'd1:   center_color = COL_O;
      32'd2:   center_color = COL_G;
      32'd3:   center_color = COL_R;
      32'd4:   center_color = COL_B;
      32'd5:   center_color = COL_Y;
      default: center_color = COL_W;
    endcase
  endfunction

endpackage

// File: rtl/color_settle.sv
// color_settle: debounces a color sensor.
// Ports:
//   clock, reset  - system clock, synchronous active-high reset
//   sample        - current sensor reading
//   valid         - reading is usable this cycle (only these cycles count)
//   clear         - forget history before a new sticker
//   accept        - this valid sample completes SETTLE_CYCLES identical readings
//   color         - last valid sample; equals the accepted color after accept
module color_settle
  import cube_pkg::*;
#(
  parameter int COLOR_W       = CUBE_COLOR_W,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [COLOR_W-1:0] sample,
  input  logic               valid,
  input  logic               clear,
  output logic               accept,
  output logic [COLOR_W-1:0] color
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(SETTLE_CYCLES);

  logic [COLOR_W-1:0] r_prev;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_match;

  // Run-length of identical valid samples; a zero count means no history yet.
  always_comb begin
    w_match    = (r_cnt != {CNT_W{1'b0}}) && (sample == r_prev);
    w_cnt_next = r_cnt;
    if (valid) begin
      if (w_match) begin
        if (r_cnt == CNT_SAT) begin
          w_cnt_next = r_cnt;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end else begin
        w_cnt_next = CNT_W'(1);
      end
    end else begin
      w_cnt_next = r_cnt;
    end
    accept = valid && (w_cnt_next == CNT_SAT);
  end

  // History registers: previous sample and run-length count.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_prev <= {COLOR_W{1'b0}};
      r_cnt  <= {CNT_W{1'b0}};
    end else if (valid) begin
      r_prev <= sample;
      r_cnt  <= w_cnt_next;
    end else begin
      r_prev <= r_prev;
      r_cnt  <= r_cnt;
    end
  end

  assign color = r_prev;

endmodule

// File: rtl/sticker_scan_ctrl.sv
// sticker_scan_ctrl: walks the cube through N_STICKERS sensor positions, asks the
// motor sequencer for setup moves, debounces the sensor reading for each sticker
// and assembles the full cube state (stickers plus fixed centers).
// Ports:
//   clock, reset        - system clock, synchronous active-high reset
//   start               - level; a rising edge starts a scan from IDLE/DONE/ERROR
//   moves_done          - pulse from the motor sequencer, requested moves finished
//   corner/edge_color   - sensor readings; color_valid marks a stable reading
//   req_moves           - one-cycle pulse requesting setup moves for step
//   step                - sticker index being scanned (N_STICKERS = restore moves)
//   cube_state          - sticker k at [k*COLOR_W +: COLOR_W], centers above
//   done/error/err_code - completion and fault status
module sticker_scan_ctrl
  import cube_pkg::*;
#(
  parameter int N_STICKERS     = 48,
  parameter int N_CORNER       = 24,
  parameter int COLOR_W        = CUBE_COLOR_W,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 2 ** 20
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              moves_done,
  input  logic [COLOR_W-1:0]                corner_color,
  input  logic [COLOR_W-1:0]                edge_color,
  input  logic                              color_valid,
  output logic                              req_moves,
  output logic [$clog2(N_STICKERS+1)-1:0]   step,
  output logic [(N_STICKERS+6)*COLOR_W-1:0] cube_state,
  output logic                              done,
  output logic                              error,
  output logic [1:0]                        err_code
);

  localparam int STEP_W = $clog2(N_STICKERS + 1);
  localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [STEP_W-1:0] STEP_END   = STEP_W'(N_STICKERS);
  localparam logic [STEP_W-1:0] STEP_EDGE  = STEP_W'(N_CORNER);
  localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
  localparam int                CUBE_W     = (N_STICKERS + 6) * COLOR_W;

  scan_state_e        r_state;
  scan_state_e        w_next;
  err_e               r_err_code;
  err_e               w_err_code;
  logic               r_start_d;
  logic               r_req_moves;
  logic               r_done;
  logic               r_error;
  logic [STEP_W-1:0]  r_step;
  logic [TO_W-1:0]    r_timeout;
  logic [COLOR_W-1:0] r_stickers [N_STICKERS];
  logic [CUBE_W-1:0]  w_cube;
  logic [COLOR_W-1:0] w_sample;
  logic [COLOR_W-1:0] w_color;
  logic               w_start_rise;
  logic               w_restart;
  logic               w_settle_valid;
  logic               w_settle_clear;
  logic               w_accept;
  logic               w_illegal;

  assign w_start_rise   = start && !r_start_d;
  assign w_restart      = w_start_rise && (r_state inside {S_IDLE, S_DONE, S_ERROR});
  assign w_sample       = (r_step < STEP_EDGE) ? corner_color : edge_color;
  assign w_settle_valid = color_valid && (r_state == S_SETTLE);
  assign w_settle_clear = (r_state == S_REQ);
  assign w_illegal      = w_settle_valid && (w_sample > COLOR_W'(COLOR_MAX));

  color_settle #(
    .COLOR_W      (COLOR_W),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clock (clock),
    .reset (reset),
    .sample(w_sample),
    .valid (w_settle_valid),
    .clear (w_settle_clear),
    .accept(w_accept),
    .color (w_color)
  );

  // Next-state and error-code logic; an illegal color outranks acceptance.
  always_comb begin
    w_next     = r_state;
    w_err_code = r_err_code;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (w_start_rise) begin
          w_next     = S_REQ;
          w_err_code = ERR_NONE;
        end else begin
          w_next = r_state;
        end
      end
      S_REQ: w_next = S_WAIT_MOVE;
      S_WAIT_MOVE: begin
        if (moves_done) begin
          if (r_step < STEP_END) begin
            w_next = S_SETTLE;
          end else begin
            w_next = S_DONE;
          end
        end else if (r_timeout == TO_LAST) begin
          w_next     = S_ERROR;
          w_err_code = ERR_TIMEOUT;
        end else begin
          w_next = S_WAIT_MOVE;
        end
      end
      S_SETTLE: begin
        if (w_illegal) begin
          w_next     = S_ERROR;
          w_err_code = ERR_COLOR;
        end else if (w_accept) begin
          w_next = S_STORE;
        end else begin
          w_next = S_SETTLE;
        end
      end
      S_STORE: w_next = S_REQ;
      default: begin
        w_next     = S_IDLE;
        w_err_code = ERR_NONE;
      end
    endcase
  end

  // State register and status outputs, registered from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_req_moves <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_code  <= ERR_NONE;
    end else begin
      r_state     <= w_next;
      r_req_moves <= (w_next == S_REQ);
      r_done      <= (w_next == S_DONE);
      r_error     <= (w_next == S_ERROR);
      r_err_code  <= w_err_code;
    end
  end

  // Start edge detector; tracks the level during reset so a start held high
  // across reset is not taken as a new edge.
  always_ff @(posedge clock) begin
    r_start_d <= start;
  end

  // Move timeout counter, free-running only while waiting for the sequencer.
  always_ff @(posedge clock) begin
    if (reset || (r_state != S_WAIT_MOVE)) begin
      r_timeout <= {TO_W{1'b0}};
    end else begin
      r_timeout <= r_timeout + TO_W'(1);
    end
  end

  // Step index and sticker storage.
  always_ff @(posedge clock) begin
    if (reset || w_restart) begin
      r_step <= {STEP_W{1'b0}};
      for (int k = 0; k < N_STICKERS; k++) begin
        r_stickers[k] <= {COLOR_W{1'b0}};
      end
    end else if (r_state == S_STORE) begin
      r_step <= r_step + STEP_W'(1);
      for (int k = 0; k < N_STICKERS; k++) begin
        if (r_step == STEP_W'(k)) begin
          r_stickers[k] <= w_color;
        end else begin
          r_stickers[k] <= r_stickers[k];
        end
      end
    end else begin
      r_step <= r_step;
    end
  end

  // Pack stickers and the fixed center colors into the flat cube_state vector.
  always_comb begin
    w_cube = {CUBE_W{1'b0}};
    for (int k = 0; k < N_STICKERS; k++) begin
      w_cube[k*COLOR_W +: COLOR_W] = r_stickers[k];
    end
    for (int f = 0; f < 6; f++) begin
      w_cube[(N_STICKERS+f)*COLOR_W +: COLOR_W] = COLOR_W'(center_color(f));
    end
  end

  assign req_moves  = r_req_moves;
  assign step       = r_step;
  assign cube_state = w_cube;
  assign done       = r_done;
  assign error      = r_error;
  assign err_code   = r_err_code;

endmodule

// File: tb/tb_sticker_scan_ctrl.sv
// tb_sticker_scan_ctrl: self-checking bench for sticker_scan_ctrl.
// A table of settle scenarios at step 0, directed full/aborted scans, and
// randomized scans whose accepted colors and latencies come from a window model
// over the list of valid readings.
module tb_sticker_scan_ctrl;

  localparam int NS = 48;
  localparam int NC = 24;
  localparam int CW = 3;
  localparam int SC = 4;
  localparam int TO = 16;
  localparam int SW = $clog2(NS + 1);

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     start;
  logic                     moves_done;
  logic [CW-1:0]            corner_color;
  logic [CW-1:0]            edge_color;
  logic                     color_valid;
  logic                     req_moves;
  logic [SW-1:0]            step;
  logic [(NS+6)*CW-1:0]     cube_state;
  logic                     done;
  logic                     error;
  logic [1:0]               err_code;

  int n_cmp  = 0;
  int n_fail = 0;
  int req_cnt = 0;
  int exp_field [NS];

  bit s_valid [32];
  int s_val   [32];
  int s_len;

  typedef struct {
    logic [15:0] vmask;
    logic [63:0] vals;   // sample i in nibble i (LSB first)
    int          len;
    int          spur;   // SETTLE cycle with a spurious moves_done, -1 none
    int          kind;   // 0 none, 1 accepted, 2 illegal color error
    int          t;      // cycles after first SETTLE cycle until req_moves/error
    int          color;
  } vec_t;

  vec_t tab [6];

  sticker_scan_ctrl #(
    .N_STICKERS    (NS),
    .N_CORNER      (NC),
    .COLOR_W       (CW),
    .SETTLE_CYCLES (SC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .moves_done  (moves_done),
    .corner_color(corner_color),
    .edge_color  (edge_color),
    .color_valid (color_valid),
    .req_moves   (req_moves),
    .step        (step),
    .cube_state  (cube_state),
    .done        (done),
    .error       (error),
    .err_code    (err_code)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (req_moves) req_cnt <= req_cnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] field(input int k);
    return 64'(cube_state[k*CW +: CW]);
  endfunction

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; moves_done = 1'b0; color_valid = 1'b0;
    corner_color = '0; edge_color = '0;
    tick(); tick();
    reset = 1'b0;
    for (int k = 0; k < NS; k++) exp_field[k] = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (!req_moves && n < 40) begin
      tick();
      n++;
    end
    chk(nm, 64'(req_moves), 64'd1);
  endtask

  // Answer a req_moves seen this cycle: optional ignored pulse in the REQ cycle,
  // then a pulse d cycles into WAIT_MOVE.
  task automatic reply_moves(input int d, input bit early);
    if (early) begin
      moves_done = 1'b1;
      tick();
      moves_done = 1'b0;
      repeat (d - 1) tick();
    end else begin
      repeat (d) tick();
    end
    moves_done = 1'b1;
    tick();
    moves_done = 1'b0;
  endtask

  task automatic put_sensor(input int k, input int v);
    if (k < NC) begin
      corner_color = CW'(v);
      edge_color   = CW'((v + 3) % 6);
    end else begin
      edge_color   = CW'(v);
      corner_color = CW'((v + 3) % 6);
    end
  endtask

  // Drive the stream from the first SETTLE cycle; report the first event seen.
  task automatic drive_stream(input int k, input int spur, input int maxc,
                              output int kind, output int t);
    kind = 0;
    t = -1;
    for (int i = 0; i < maxc && kind == 0; i++) begin
      if (i < s_len) begin
        color_valid = s_valid[i];
        put_sensor(k, s_val[i]);
      end else begin
        color_valid = 1'b0;
        put_sensor(k, int'($urandom_range(0, 7)));
      end
      moves_done = (i == spur);
      tick();
      moves_done = 1'b0;
      if (error) begin
        kind = 2; t = i + 1;
      end else if (req_moves) begin
        kind = 1; t = i + 1;
      end
    end
    color_valid = 1'b0;
  endtask

  // Reference: accept at the first valid reading whose last SC valid readings
  // are identical; STORE follows, then req_moves one cycle later.
  task automatic model(output int kind, output int t, output int col);
    int q[$];
    bool_same: begin end
    kind = 0; t = -1; col = -1;
    for (int i = 0; i < s_len; i++) begin
      if (s_valid[i]) begin
        if (s_val[i] > 5) begin
          kind = 2; t = i + 1;
          return;
        end
        q.push_back(s_val[i]);
        if (q.size() >= SC) begin
          bit same = 1'b1;
          for (int j = 1; j < SC; j++) begin
            if (q[q.size()-1-j] != q[q.size()-1]) same = 1'b0;
          end
          if (same) begin
            kind = 1; t = i + 2; col = s_val[i];
            return;
          end
        end
      end
    end
  endtask

  task automatic run_stickers(input int first, input int last, input bit rnd);
    int d, kind, t, ek, et, ec, p, a, b, c;
    for (int k = first; k <= last; k++) begin
      chk($sformatf("step_at_req%0d", k), 64'(step), 64'(k));
      d = rnd ? int'($urandom_range(1, 5)) : 3;
      reply_moves(d, rnd && ($urandom_range(0, 3) == 0));
      if (!rnd) begin
        s_len = SC;
        for (int i = 0; i < SC; i++) begin
          s_valid[i] = 1'b1; s_val[i] = k % 6;
        end
      end else begin
        p = int'($urandom_range(0, 10));
        a = int'($urandom_range(0, 5));
        b = int'($urandom_range(0, 5));
        c = int'($urandom_range(0, 5));
        for (int i = 0; i < p; i++) begin
          s_valid[i] = $urandom_range(0, 1) == 1;
          s_val[i] = s_valid[i] ? (($urandom_range(0, 1) == 1) ? a : b)
                                : int'($urandom_range(0, 7));
        end
        for (int i = p; i < p + SC; i++) begin
          s_valid[i] = 1'b1; s_val[i] = c;
        end
        s_len = p + SC;
      end
      model(ek, et, ec);
      drive_stream(k, -1, 40, kind, t);
      chk($sformatf("kind%0d", k), 64'(kind), 64'(ek));
      chk($sformatf("latency%0d", k), 64'(t), 64'(et));
      exp_field[k] = ec;
    end
  endtask

  task automatic check_fields(input string tag);
    for (int k = 0; k < NS; k++)
      chk($sformatf("%s_field%0d", tag, k), field(k), 64'(exp_field[k]));
    for (int f = 0; f < 6; f++)
      chk($sformatf("%s_center%0d", tag, f), field(NS + f), 64'(f));
  endtask

  initial begin
    int kind, t, r0, n;

    tab[0] = '{16'h003F, 64'h0000_0000_0033_3322, 6, -1, 1, 7, 3};
    tab[1] = '{16'h0055, 64'h0000_0000_0444_4444, 7,  1, 1, 8, 4};
    tab[2] = '{16'h0007, 64'h0000_0000_0000_0711, 3, -1, 2, 3, -1};
    tab[3] = '{16'h007F, 64'h0000_0000_0111_1000, 7, -1, 1, 8, 1};
    tab[4] = '{16'h0017, 64'h0000_0000_0005_7555, 5, -1, 1, 6, 5};
    tab[5] = '{16'h00FF, 64'h0000_0000_3232_3232, 8, -1, 0, -1, -1};

    // Reset state, and a moves_done in IDLE is ignored.
    do_reset();
    chk("rst_step", 64'(step), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_err_code", 64'(err_code), 64'd0);
    chk("rst_req", 64'(req_moves), 64'd0);
    check_fields("rst");
    moves_done = 1'b1; tick(); moves_done = 1'b0; repeat (3) tick();
    chk("idle_no_req", 64'(req_cnt), 64'd0);

    // Settle scenarios at step 0.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      do_start();
      wait_req($sformatf("tab%0d_req", v));
      reply_moves(3, 1'b0);
      s_len = tab[v].len;
      for (int i = 0; i < s_len; i++) begin
        s_valid[i] = tab[v].vmask[i];
        s_val[i]   = int'(tab[v].vals[i*4 +: 4]);
      end
      drive_stream(0, tab[v].spur, 24, kind, t);
      chk($sformatf("tab%0d_kind", v), 64'(kind), 64'(tab[v].kind));
      chk($sformatf("tab%0d_time", v), 64'(t), 64'(tab[v].t));
      if (tab[v].kind == 1) begin
        chk($sformatf("tab%0d_step", v), 64'(step), 64'd1);
        chk($sformatf("tab%0d_color", v), field(0), 64'(tab[v].color));
      end else if (tab[v].kind == 2) begin
        chk($sformatf("tab%0d_err_code", v), 64'(err_code), 64'd2);
        chk($sformatf("tab%0d_err_step", v), 64'(step), 64'd0);
      end else begin
        chk($sformatf("tab%0d_no_done", v), 64'(done), 64'd0);
      end
    end

    // Full scan with colors k mod 6, moves_done 3 cycles after each request.
    do_reset();
    r0 = req_cnt;
    do_start();
    wait_req("full_req0");
    run_stickers(0, NS - 1, 1'b0);
    chk("full_final_step", 64'(step), 64'(NS));
    reply_moves(3, 1'b0);
    chk("full_done", 64'(done), 64'd1);
    chk("full_error", 64'(error), 64'd0);
    chk("full_req_count", 64'(req_cnt - r0), 64'd49);
    check_fields("full");
    moves_done = 1'b1; tick(); moves_done = 1'b0; repeat (4) tick();
    chk("full_done_held", 64'(done), 64'd1);
    do_start();
    chk("restart_done_clr", 64'(done), 64'd0);
    chk("restart_req", 64'(req_moves), 64'd1);
    chk("restart_step", 64'(step), 64'd0);
    chk("restart_field5_clr", field(5), 64'd0);

    // Move timeout: no moves_done after this request.
    n = 0;
    while (!error && n < 40) begin
      tick();
      n++;
    end
    chk("timeout_cycles", 64'(n), 64'd17);
    chk("timeout_err_code", 64'(err_code), 64'd1);
    chk("timeout_step", 64'(step), 64'd0);

    // Randomized scans against the window model.
    for (int r = 0; r < 2; r++) begin
      do_reset();
      r0 = req_cnt;
      do_start();
      wait_req("rnd_req0");
      run_stickers(0, NS - 1, 1'b1);
      chk("rnd_final_step", 64'(step), 64'(NS));
      reply_moves(int'($urandom_range(1, 5)), 1'b0);
      chk("rnd_done", 64'(done), 64'd1);
      chk("rnd_req_count", 64'(req_cnt - r0), 64'd49);
      check_fields("rnd");
    end

    // Illegal color on the edge sensor at step 30, then restart.
    do_reset();
    do_start();
    wait_req("ill_req0");
    run_stickers(0, 29, 1'b0);
    reply_moves(3, 1'b0);
    s_len = 1; s_valid[0] = 1'b1; s_val[0] = 7;
    drive_stream(30, -1, 10, kind, t);
    chk("ill_kind", 64'(kind), 64'd2);
    chk("ill_time", 64'(t), 64'd1);
    chk("ill_err_code", 64'(err_code), 64'd2);
    chk("ill_step", 64'(step), 64'd30);
    chk("ill_field29", field(29), 64'(29 % 6));
    do_start();
    chk("ill_restart_req", 64'(req_moves), 64'd1);
    chk("ill_restart_step", 64'(step), 64'd0);
    chk("ill_restart_error", 64'(error), 64'd0);
    chk("ill_restart_err_code", 64'(err_code), 64'd0);

    // Reset during SETTLE at step 10 abandons the scan.
    run_stickers(0, 9, 1'b0);
    reply_moves(3, 1'b0);
    color_valid = 1'b1; put_sensor(10, 2);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    color_valid = 1'b0;
    chk("midrst_step", 64'(step), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_req", 64'(req_moves), 64'd0);
    chk("midrst_field0", field(0), 64'd0);
    r0 = req_cnt;
    for (int i = 0; i < 30; i++) begin
      moves_done = (i % 7 == 3);
      tick();
    end
    moves_done = 1'b0;
    chk("midrst_no_req", 64'(req_cnt - r0), 64'd0);
    do_start();
    chk("midrst_restart_req", 64'(req_moves), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
